// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I-subset control unit and its ALU.
// State, opcode, ALUOp and ALUControl codes live here so datapath and control agree.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_SUB    = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
  localparam logic [1:0] ALUOP_UNUSED = 2'b11;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Moore control word; enables are gated by reset in the top level.
  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

  function automatic logic op_supported(input logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
           (op == OP_I)  || (op == OP_BEQ) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps ALUOp plus instruction function bits onto the ALU operation select.
// Purely combinational; unsupported funct3 values fall back to ADD without trapping.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [2:0] i_funct3,
  input  logic       i_op5,
  input  logic       i_funct7b5,
  output logic [2:0] o_alu_control
);

  // SUB only for R-type with funct7[5]; I-type with instr[30] set stays ADD.
  logic w_is_sub;
  assign w_is_sub = i_op5 & i_funct7b5;

  always_comb begin
    o_alu_control = ALU_ADD;
    case (i_alu_op)
      ALUOP_ADD: o_alu_control = ALU_ADD;
      ALUOP_SUB: o_alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct3)
          3'b000:  o_alu_control = w_is_sub ? ALU_SUB : ALU_ADD;
          3'b110:  o_alu_control = ALU_OR;
          3'b111:  o_alu_control = ALU_AND;
          default: o_alu_control = ALU_ADD;
        endcase
      end
      default: o_alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I-subset control FSM: sequences fetch/decode/execute/memory/writeback
// and drives every datapath select and enable; outputs are decoded from the state register.
module multicycle_control
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic [2:0] ALUControl,
  output logic       Illegal
);

  state_t r_state;
  ctrl_t  w_ctrl;
  logic   w_op_legal;
  logic   w_run;

  assign w_op_legal = op_supported(op);
  assign w_run      = ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FETCH;
    end else begin
      case (r_state)
        FETCH: r_state <= DECODE;
        DECODE: begin
          case (op)
            OP_LW, OP_SW: r_state <= MEMADR;
            OP_R:         r_state <= EXECUTER;
            OP_I:         r_state <= EXECUTEI;
            OP_BEQ:       r_state <= BEQ;
            OP_JAL:       r_state <= JAL;
            default:      r_state <= FETCH;
          endcase
        end
        MEMADR:   r_state <= (op == OP_LW) ? MEMREAD : MEMWRITE;
        MEMREAD:  r_state <= MEMWB;
        MEMWB:    r_state <= FETCH;
        MEMWRITE: r_state <= FETCH;
        EXECUTER: r_state <= ALUWB;
        EXECUTEI: r_state <= ALUWB;
        ALUWB:    r_state <= FETCH;
        BEQ:      r_state <= FETCH;
        JAL:      r_state <= ALUWB;
        default:  r_state <= FETCH;
      endcase
    end
  end

  always_comb begin
    w_ctrl = '0;
    case (r_state)
      FETCH: begin
        w_ctrl.ir_write   = 1'b1;
        w_ctrl.pc_update  = 1'b1;
        w_ctrl.alu_src_b  = 2'b10;
        w_ctrl.result_src = 2'b10;
      end
      DECODE: begin
        w_ctrl.alu_src_a = 2'b01;
        w_ctrl.alu_src_b = 2'b01;
      end
      MEMADR: begin
        w_ctrl.alu_src_a = 2'b10;
        w_ctrl.alu_src_b = 2'b01;
      end
      MEMREAD: begin
        w_ctrl.adr_src = 1'b1;
      end
      MEMWB: begin
        w_ctrl.result_src = 2'b01;
        w_ctrl.reg_write  = 1'b1;
      end
      MEMWRITE: begin
        w_ctrl.adr_src   = 1'b1;
        w_ctrl.mem_write = 1'b1;
      end
      EXECUTER: begin
        w_ctrl.alu_src_a = 2'b10;
        w_ctrl.alu_op    = ALUOP_FUNCT;
      end
      EXECUTEI: begin
        w_ctrl.alu_src_a = 2'b10;
        w_ctrl.alu_src_b = 2'b01;
        w_ctrl.alu_op    = ALUOP_FUNCT;
      end
      ALUWB: begin
        w_ctrl.reg_write = 1'b1;
      end
      BEQ: begin
        w_ctrl.alu_src_a = 2'b10;
        w_ctrl.alu_op    = ALUOP_SUB;
        w_ctrl.branch    = 1'b1;
      end
      JAL: begin
        w_ctrl.alu_src_a = 2'b01;
        w_ctrl.alu_src_b = 2'b10;
        w_ctrl.pc_update = 1'b1;
      end
      default: w_ctrl = '0;
    endcase
  end

  // Zero only matters through branch, which is asserted solely in BEQ.
  assign PCWrite   = w_run & (w_ctrl.pc_update | (w_ctrl.branch & Zero));
  assign MemWrite  = w_run & w_ctrl.mem_write;
  assign IRWrite   = w_run & w_ctrl.ir_write;
  assign RegWrite  = w_run & w_ctrl.reg_write;
  assign Illegal   = w_run & (r_state == DECODE) & ~w_op_legal;

  assign AdrSrc    = w_ctrl.adr_src;
  assign ResultSrc = w_ctrl.result_src;
  assign ALUSrcA   = w_ctrl.alu_src_a;
  assign ALUSrcB   = w_ctrl.alu_src_b;
  assign ImmSrc    = imm_src_of(op);

  alu_decoder u_alu_decoder (
    .i_alu_op      (w_ctrl.alu_op),
    .i_funct3      (funct3),
    .i_op5         (op[5]),
    .i_funct7b5    (funct7b5),
    .o_alu_control (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed instructions, reset abort, then random
// instruction stream checked cycle by cycle against per-instruction expected output sequences.
module tb_multicycle_control;
  import ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .RegWrite(RegWrite), .ALUControl(ALUControl), .Illegal(Illegal)
  );

  // One expected cycle of an instruction; PCWrite is pcu | (br & Zero).
  typedef struct packed {
    logic       pcu;
    logic       br;
    logic       adr;
    logic       memw;
    logic       irw;
    logic [1:0] res;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic       regw;
    logic [2:0] aluc;
    logic       ill;
  } step_t;

  step_t exp_q[$];

  function automatic step_t mk(input logic pcu, input logic br, input logic adr, input logic memw,
                               input logic irw, input logic [1:0] res, input logic [1:0] srca,
                               input logic [1:0] srcb, input logic regw, input logic [2:0] aluc,
                               input logic ill);
    step_t s;
    s.pcu = pcu; s.br = br; s.adr = adr; s.memw = memw; s.irw = irw; s.res = res;
    s.srca = srca; s.srcb = srcb; s.regw = regw; s.aluc = aluc; s.ill = ill;
    return s;
  endfunction

  function automatic logic [2:0] arith_ref(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    if (f3 == 3'b110) return 3'b001;
    if (f3 == 3'b111) return 3'b000;
    if (f3 == 3'b000 && o == 7'b0110011 && f7) return 3'b011;
    return 3'b010;
  endfunction

  function automatic logic [1:0] imm_ref(input logic [6:0] o);
    if (o == 7'b0100011) return 2'b01;
    if (o == 7'b1100011) return 2'b10;
    if (o == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic legal_ref(input logic [6:0] o);
    return o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
  endfunction

  // Expected cycle-by-cycle behaviour of one instruction, FETCH through its last state.
  task automatic build(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    step_t wb;
    wb = mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 3'b010, 0);
    exp_q.delete();
    exp_q.push_back(mk(1, 0, 0, 0, 1, 2'b10, 2'b00, 2'b10, 0, 3'b010, 0));
    exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, 3'b010, !legal_ref(o)));
    case (o)
      7'b0000011: begin
        exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 3'b010, 0));
        exp_q.push_back(mk(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 3'b010, 0));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 1, 3'b010, 0));
      end
      7'b0100011: begin
        exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 3'b010, 0));
        exp_q.push_back(mk(0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 3'b010, 0));
      end
      7'b0110011: begin
        exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, arith_ref(o, f3, f7), 0));
        exp_q.push_back(wb);
      end
      7'b0010011: begin
        exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, arith_ref(o, f3, f7), 0));
        exp_q.push_back(wb);
      end
      7'b1100011: exp_q.push_back(mk(0, 1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 3'b011, 0));
      7'b1101111: begin
        exp_q.push_back(mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 0, 3'b010, 0));
        exp_q.push_back(wb);
      end
      default: ;
    endcase
  endtask

  task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Entered 1 time unit after the edge that starts this instruction's FETCH cycle.
  // zmode: 0 random Zero, 1 Zero held high, 2 Zero held low. nsteps < 0 runs to completion.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input int zmode, input int nsteps);
    int n;
    logic z;
    step_t s;
    logic [16:0] obs, expv;
    build(o, f3, f7);
    op = o; funct3 = f3; funct7b5 = f7;
    n = (nsteps < 0) ? exp_q.size() : nsteps;
    for (int k = 0; k < n; k++) begin
      z = (zmode == 0) ? 1'($urandom_range(0, 1)) : (zmode == 1);
      Zero = z;
      #1;
      s = exp_q[k];
      expv = {s.pcu | (s.br & z), s.adr, s.memw, s.irw, s.res, s.srca, s.srcb,
              imm_ref(o), s.regw, s.aluc, s.ill};
      obs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
             ImmSrc, RegWrite, ALUControl, Illegal};
      check($sformatf("op%b_f3%b_f7%b_step%0d", o, f3, f7, k), obs, expv);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [6:0] ro;
    logic [2:0] rf3;
    reset = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b1;
    @(posedge clk); #2;
    check("reset_enables", {12'd0, PCWrite, MemWrite, IRWrite, RegWrite, Illegal}, 17'd0);
    check("reset_fetch_srcb", {15'd0, ALUSrcB}, {15'd0, 2'b10});
    @(posedge clk); #1;
    reset = 1'b0;

    run_instr(7'b0000011, 3'b010, 1'b0, 0, -1);
    run_instr(7'b0100011, 3'b010, 1'b0, 0, -1);
    run_instr(7'b0110011, 3'b000, 1'b1, 0, -1);
    run_instr(7'b0110011, 3'b000, 1'b0, 0, -1);
    run_instr(7'b0010011, 3'b110, 1'b1, 0, -1);
    run_instr(7'b0010011, 3'b000, 1'b1, 0, -1);
    run_instr(7'b1100011, 3'b000, 1'b0, 1, -1);
    run_instr(7'b1100011, 3'b000, 1'b0, 2, -1);
    run_instr(7'b1101111, 3'b000, 1'b0, 0, -1);
    run_instr(7'b1111111, 3'b000, 1'b0, 1, -1);

    // Abort an R-type in EXECUTER: two reset edges, then release into FETCH.
    run_instr(7'b0110011, 3'b000, 1'b1, 0, 2);
    reset = 1'b1; Zero = 1'b1;
    #1;
    check("rst_exec_enables", {12'd0, PCWrite, MemWrite, IRWrite, RegWrite, Illegal}, 17'd0);
    check("rst_exec_srca", {15'd0, ALUSrcA}, {15'd0, 2'b10});
    @(posedge clk); #1;
    check("rst_hold1_enables", {12'd0, PCWrite, MemWrite, IRWrite, RegWrite, Illegal}, 17'd0);
    @(posedge clk); #1;
    check("rst_hold2_enables", {12'd0, PCWrite, MemWrite, IRWrite, RegWrite, Illegal}, 17'd0);
    reset = 1'b0;
    #1;
    check("rst_release_fetch", {12'd0, IRWrite, PCWrite, ALUControl}, {12'd0, 1'b1, 1'b1, 3'b010});
    #1;
    op = 7'b0000011;
    run_instr(7'b0000011, 3'b000, 1'b0, 0, -1);

    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 6))
        0: ro = 7'b0000011;
        1: ro = 7'b0100011;
        2: ro = 7'b0110011;
        3: ro = 7'b0010011;
        4: ro = 7'b1100011;
        5: ro = 7'b1101111;
        default: begin
          ro = 7'($urandom);
          while (legal_ref(ro)) ro = 7'($urandom);
        end
      endcase
      case ($urandom_range(0, 3))
        0: rf3 = 3'b000;
        1: rf3 = 3'b110;
        2: rf3 = 3'b111;
        default: rf3 = 3'($urandom);
      endcase
      run_instr(ro, rf3, 1'($urandom_range(0, 1)), 0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
